// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one saturating
// signed adder, with a one-entry result register and a saturation counter.
module adder_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IN1_WIDTH = 20,
  parameter int IN2_WIDTH = 32,
  parameter int OUT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*IN1_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*IN2_WIDTH-1:0]   req_b,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [OUT_WIDTH-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic                           rsp_sat,
  output logic [15:0]                    sat_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 rsp_sat_q, rsp_sat_d;
  logic [15:0]          sat_count_q, sat_count_d;

  logic                        gnt_found;
  logic [ID_W-1:0]             gnt_idx;
  logic signed [IN1_WIDTH-1:0] a_sel;
  logic signed [IN2_WIDTH-1:0] b_sel;
  logic [OUT_WIDTH:0]          sat_res;
  logic                        slot_free;
  logic                        xfer;
  int                          idx;

  // Returns {saturated, clamped_sum}; OUT_WIDTH+1 bits hold the exact sum.
  function automatic logic [OUT_WIDTH:0] sat_add(
    input logic signed [IN1_WIDTH-1:0] a,
    input logic signed [IN2_WIDTH-1:0] b
  );
    logic signed [OUT_WIDTH:0] sum;
    logic [OUT_WIDTH-1:0]      max_v;
    logic [OUT_WIDTH-1:0]      min_v;
    sum   = {{(OUT_WIDTH+1-IN1_WIDTH){a[IN1_WIDTH-1]}}, a}
          + {{(OUT_WIDTH+1-IN2_WIDTH){b[IN2_WIDTH-1]}}, b};
    max_v = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    min_v = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    if (sum[OUT_WIDTH] != sum[OUT_WIDTH-1]) begin
      sat_add = {1'b1, (sum[OUT_WIDTH] ? min_v : max_v)};
    end else begin
      sat_add = {1'b0, sum[OUT_WIDTH-1:0]};
    end
  endfunction

  // Rotating priority search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    a_sel     = '0;
    b_sel     = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + 1 + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
        a_sel     = req_a[idx*IN1_WIDTH +: IN1_WIDTH];
        b_sel     = req_b[idx*IN2_WIDTH +: IN2_WIDTH];
      end
    end
  end

  // reset gates the grant so no handshake is seen while state is being cleared
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign xfer      = gnt_found && enable && slot_free && !reset;
  assign req_ready = xfer ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign sat_res   = sat_add(a_sel, b_sel);

  always_comb begin
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_sat_d    = rsp_sat_q;
    sat_count_d  = sat_count_q;
    if (xfer) begin
      last_grant_d = gnt_idx;
      rsp_valid_d  = 1'b1;
      rsp_data_d   = sat_res[OUT_WIDTH-1:0];
      rsp_sat_d    = sat_res[OUT_WIDTH];
      rsp_id_d     = gnt_idx;
      if (sat_res[OUT_WIDTH] && (sat_count_q != 16'hFFFF)) begin
        sat_count_d = sat_count_q + 16'd1;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Result register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_sat_q    <= 1'b0;
      sat_count_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sat_q    <= rsp_sat_d;
      sat_count_q  <= sat_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sat   = rsp_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: arbitration order, saturation,
// backpressure, enable gating and asynchronous reset.
module tb_adder_share_arbiter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [79:0] req_a;
  logic [127:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_sat;
  logic [15:0] sat_count;

  int n_tests = 0;
  int n_fail  = 0;

  adder_share_arbiter #(
    .NUM_REQ(4), .IN1_WIDTH(20), .IN2_WIDTH(32), .OUT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_sat(rsp_sat),
    .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [19:0] a, input logic [31:0] b);
    req_a[i*20 +: 20] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; rsp_ready = 1'b1; req_valid = 4'b1111;
    req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_tests++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    n_tests++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
    n_tests++; if (rsp_sat !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_sat got %b exp 0", rsp_sat); end
    n_tests++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL reset_sat_count got %0d exp 0", sat_count); end
    @(negedge clk);
    req_valid = 4'b0000;
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'd1; exp_d[1] = 32'd12; exp_d[2] = 32'd23; exp_d[3] = 32'd34;
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_op(i, 20'(i + 1), 32'(10 * i));
    req_valid = 4'b1111; rsp_ready = 1'b1; enable = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_grant0 got %b exp 0001", req_ready); end
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      #1;
      n_tests++; if (req_ready !== (4'b0001 << (c % 4))) begin n_fail++; $display("FAIL rr_grant c=%0d got %b exp %b", c, req_ready, 4'b0001 << (c % 4)); end
      n_tests++; if (rsp_id !== 2'((c - 1) % 4) || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_rsp_id c=%0d got %0d/%b exp %0d/1", c, rsp_id, rsp_valid, (c - 1) % 4); end
      n_tests++; if (rsp_data !== exp_d[(c - 1) % 4]) begin n_fail++; $display("FAIL rr_rsp_data c=%0d got %0d exp %0d", c, rsp_data, exp_d[(c - 1) % 4]); end
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_tests++; if (rsp_id !== 2'd3 || rsp_data !== 32'd34) begin n_fail++; $display("FAIL rr_last got %0d/%0d exp 3/34", rsp_id, rsp_data); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_idle_ready got %b exp 0000", req_ready); end
    @(negedge clk);
    #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    set_op(0, 20'h7FFFF, 32'h7FFFFFFF);
    req_valid = 4'b0001;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL sat_grant got %b exp 0001", req_ready); end
    @(negedge clk);
    set_op(0, 20'h80000, 32'h80000000);
    #1;
    n_tests++; if (rsp_data !== 32'h7FFFFFFF || rsp_sat !== 1'b1) begin n_fail++; $display("FAIL sat_max got %h/%b exp 7fffffff/1", rsp_data, rsp_sat); end
    n_tests++; if (sat_count !== 16'd1) begin n_fail++; $display("FAIL sat_count1 got %0d exp 1", sat_count); end
    @(negedge clk);
    set_op(0, 20'd5, -32'sd7);
    #1;
    n_tests++; if (rsp_data !== 32'h80000000 || rsp_sat !== 1'b1) begin n_fail++; $display("FAIL sat_min got %h/%b exp 80000000/1", rsp_data, rsp_sat); end
    n_tests++; if (sat_count !== 16'd2) begin n_fail++; $display("FAIL sat_count2 got %0d exp 2", sat_count); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_tests++; if (rsp_data !== 32'hFFFFFFFE || rsp_sat !== 1'b0) begin n_fail++; $display("FAIL sat_none got %h/%b exp fffffffe/0", rsp_data, rsp_sat); end
    n_tests++; if (sat_count !== 16'd2) begin n_fail++; $display("FAIL sat_count_hold got %0d exp 2", sat_count); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_op(1, 20'd7, 32'd8);
    set_op(2, 20'd100, 32'd200);
    req_valid = 4'b0110; rsp_ready = 1'b0;
    #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_first_grant got %b exp 0010", req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd15 || rsp_id !== 2'd1) begin n_fail++; $display("FAIL bp_hold c=%0d got %b/%0d/%0d exp 1/15/1", c, rsp_valid, rsp_data, rsp_id); end
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready c=%0d got %b exp 0000", c, req_ready); end
    end
    rsp_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_grant got %b exp 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'd300) begin n_fail++; $display("FAIL bp_no_bubble got %b/%0d/%0d exp 1/2/300", rsp_valid, rsp_id, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_skip_enable();
    @(negedge clk);
    set_op(1, 20'd1, 32'd2);
    set_op(3, 20'd1, 32'd1);
    req_valid = 4'b1010; rsp_ready = 1'b1; enable = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL skip_grant3 got %b exp 1000", req_ready); end
    @(negedge clk);
    #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL skip_grant1 got %b exp 0010", req_ready); end
    @(negedge clk);
    enable = 1'b0;
    #1;
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL en_off_ready got %b exp 0000", req_ready); end
    n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'd3) begin n_fail++; $display("FAIL en_off_pending got %b/%0d/%0d exp 1/1/3", rsp_valid, rsp_id, rsp_data); end
    @(negedge clk);
    #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL en_off_drain got %b exp 0", rsp_valid); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL en_off_ready2 got %b exp 0000", req_ready); end
    enable = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL en_on_grant got %b exp 1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    set_op(0, 20'h7FFFF, 32'h7FFFFFFF);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 4'b0000; rsp_ready = 1'b0;
    #1;
    n_tests++; if (sat_count !== 16'd5 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset got %0d/%b exp 5/1", sat_count, rsp_valid); end
    #2;
    req_valid = 4'b1111;
    reset = 1'b1;
    #1;
    n_tests++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 2'd0 || rsp_sat !== 1'b0) begin n_fail++; $display("FAIL async_reset_rsp got %b/%h/%0d/%b exp 0/0/0/0", rsp_valid, rsp_data, rsp_id, rsp_sat); end
    n_tests++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL async_reset_cnt got %0d exp 0", sat_count); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL async_reset_ready got %b exp 0000", req_ready); end
    @(negedge clk);
    reset = 1'b0; rsp_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL post_reset_grant got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || sat_count !== 16'd1) begin n_fail++; $display("FAIL post_reset_rsp got %b/%0d/%0d exp 1/0/1", rsp_valid, rsp_id, sat_count); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_saturation();
    test_backpressure();
    test_skip_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
